// File: rtl/divisor_frecuencia_if.sv
// Control/status bundle of the frequency divider: run enable in, divided clock and period strobe out.
interface divisor_frecuencia_if;
  logic habilitar;
  logic salida;
  logic pulso;

  modport master (output habilitar, input salida, input pulso);
  modport slave  (input habilitar, output salida, output pulso);
endinterface

// File: rtl/divisor_frecuencia.sv
// Divides clock by DIVISOR: salida is the registered divided clock, pulso strobes once per salida period.
// Defining DIVISOR_FRECUENCIA_ODD50_EN gives odd DIVISOR a 50% duty through a falling-edge stage.
module divisor_frecuencia #(
  parameter int unsigned DIVISOR = 50000000,
  parameter int unsigned ANCHO   = $clog2(DIVISOR)
) (
  input logic                 clock,
  input logic                 reset,
  divisor_frecuencia_if.slave bus
);

  if (DIVISOR < 2) begin : g_divisor_invalido
    $error("divisor_frecuencia: DIVISOR must be at least 2");
  end
  if (ANCHO < $clog2(DIVISOR)) begin : g_ancho_invalido
    $error("divisor_frecuencia: ANCHO too small to hold DIVISOR-1");
  end

  localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(DIVISOR - 1);
  // First count value of the high phase: low lasts ceil(N/2) counts.
  localparam logic [ANCHO-1:0] UMBRAL = ANCHO'(DIVISOR - DIVISOR / 2);

  logic [ANCHO-1:0] c;
  logic [ANCHO-1:0] c_sig;
  logic             alto;
  logic             pulso_q;

  always_comb begin
    c_sig = c;
    if (bus.habilitar) begin
      c_sig = (c == ULTIMO) ? '0 : c + ANCHO'(1);
    end
  end

  // salida is taken from the next count so it is a clean flop output, never decoded from c.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c       <= '0;
      alto    <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      c       <= c_sig;
      alto    <= (c_sig >= UMBRAL);
      pulso_q <= bus.habilitar && (c == ULTIMO);
    end
  end

  assign bus.pulso = pulso_q;

`ifdef DIVISOR_FRECUENCIA_ODD50_EN
  if (DIVISOR % 2 == 1) begin : g_impar
    localparam logic [ANCHO-1:0] ANTES = UMBRAL - ANCHO'(1);
    logic adelanto;

    // Raises salida half a clock early; it overlaps alto for half a cycle so the OR cannot glitch.
    always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
        adelanto <= 1'b0;
      end else begin
        adelanto <= bus.habilitar && (c == ANTES);
      end
    end

    assign bus.salida = alto | adelanto;
  end else begin : g_par
    assign bus.salida = alto;
  end
`else
  assign bus.salida = alto;
`endif

endmodule

// File: tb/tb_divisor_frecuencia.sv
// Randomized bench for divisor_frecuencia at N=2, 4 and 5 against a count-of-enabled-edges model.
module tb_divisor_frecuencia;

  logic clock = 1'b0;
  logic reset = 1'b0;

  divisor_frecuencia_if if2 ();
  divisor_frecuencia_if if4 ();
  divisor_frecuencia_if if5 ();

  divisor_frecuencia #(.DIVISOR(2)) u_div2 (.clock(clock), .reset(reset), .bus(if2.slave));
  divisor_frecuencia #(.DIVISOR(4)) u_div4 (.clock(clock), .reset(reset), .bus(if4.slave));
  divisor_frecuencia #(.DIVISOR(5)) u_div5 (.clock(clock), .reset(reset), .bus(if5.slave));

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Enabled rising edges seen since the last reset, per instance.
  int e2 = 0;
  int e4 = 0;
  int e5 = 0;

  longint t5[$];
  bit     v5[$];
  longint t2[$];
  bit     v2[$];

  always @(if5.salida) begin
    t5.push_back(longint'($time));
    v5.push_back(if5.salida);
  end

  always @(if2.salida) begin
    t2.push_back(longint'($time));
    v2.push_back(if2.salida);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_sal(input int e, input int n);
    return (e % n) >= (n - n / 2);
  endfunction

  function automatic logic exp_pul(input bit h, input int e, input int n);
    return h && (e % n == 0);
  endfunction

  task automatic set_hab(input bit h);
    if2.habilitar = h;
    if4.habilitar = h;
    if5.habilitar = h;
  endtask

  task automatic check_all(input string tag, input bit h);
    chk({tag, "_n2_salida"}, 32'(if2.salida), 32'(exp_sal(e2, 2)));
    chk({tag, "_n2_pulso"},  32'(if2.pulso),  32'(exp_pul(h, e2, 2)));
    chk({tag, "_n4_salida"}, 32'(if4.salida), 32'(exp_sal(e4, 4)));
    chk({tag, "_n4_pulso"},  32'(if4.pulso),  32'(exp_pul(h, e4, 4)));
    chk({tag, "_n5_salida"}, 32'(if5.salida), 32'(exp_sal(e5, 5)));
    chk({tag, "_n5_pulso"},  32'(if5.pulso),  32'(exp_pul(h, e5, 5)));
  endtask

  task automatic step(input string tag, input bit h);
    set_hab(h);
    @(posedge clock);
    if (h) begin
      e2++;
      e4++;
      e5++;
    end
    #1;
    check_all(tag, h);
  endtask

  // Called 1 ns after a rising edge: asserts reset mid-cycle, checks outputs clear with no edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, "_n2_salida"}, 32'(if2.salida), 32'd0);
    chk({tag, "_n2_pulso"},  32'(if2.pulso),  32'd0);
    chk({tag, "_n4_salida"}, 32'(if4.salida), 32'd0);
    chk({tag, "_n4_pulso"},  32'(if4.pulso),  32'd0);
    chk({tag, "_n5_salida"}, 32'(if5.salida), 32'd0);
    chk({tag, "_n5_pulso"},  32'(if5.pulso),  32'd0);
    e2 = 0;
    e4 = 0;
    e5 = 0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint hi5, lo5, per2, hi2;
    int     exp_hi5, exp_lo5;
    int     first_rise;

    set_hab(1'b0);
    #1;
    reset = 1'b1;
    #1;
    check_all("reset", 1'b0);

    @(posedge clock);
    #1;
    reset = 1'b0;

    // Free-running after release: 0,0,1,1 for N=4 with pulso on cycles 4 and 8.
    for (int i = 0; i < 12; i++) step("run", 1'b1);

    // Hold three cycles at c=2 of the N=4 divider, then resume.
    while (e4 % 4 != 2) step("to_c2", 1'b1);
    for (int i = 0; i < 3; i++) step("hold", 1'b0);
    for (int i = 0; i < 6; i++) step("resume", 1'b1);

    // Asynchronous reset in the middle of the c=3 cycle.
    while (e4 % 4 != 3) step("to_c3", 1'b1);
    chk("pre_reset_n4_salida", 32'(if4.salida), 32'd1);
    do_reset("rst_mid");
    for (int i = 0; i < 12; i++) step("restart", 1'b1);

    // Edge-time measurements over a continuously enabled stretch.
    t5.delete();
    v5.delete();
    t2.delete();
    v2.delete();
    for (int i = 0; i < 20; i++) step("timing", 1'b1);

`ifdef DIVISOR_FRECUENCIA_ODD50_EN
    exp_hi5 = 25;
    exp_lo5 = 25;
`else
    exp_hi5 = 20;
    exp_lo5 = 30;
`endif
    hi5 = -1;
    lo5 = -1;
    for (int i = 0; i + 1 < t5.size(); i++) begin
      if (v5[i] && hi5 < 0) hi5 = t5[i+1] - t5[i];
      if (!v5[i] && lo5 < 0) lo5 = t5[i+1] - t5[i];
    end
    chk("n5_high_ns", 32'(hi5), 32'(exp_hi5));
    chk("n5_low_ns",  32'(lo5), 32'(exp_lo5));

    per2 = -1;
    hi2 = -1;
    first_rise = -1;
    for (int i = 0; i < t2.size(); i++) begin
      if (v2[i]) begin
        if (first_rise < 0) first_rise = i;
        else if (per2 < 0) per2 = t2[i] - t2[first_rise];
        if (hi2 < 0 && i + 1 < t2.size()) hi2 = t2[i+1] - t2[i];
      end
    end
    chk("n2_period_ns", 32'(per2), 32'd20);
    chk("n2_high_ns",   32'(hi2),  32'd10);

    // Random enable pattern with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
      else step("rnd", $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divisor_frecuencia.md
DIVISOR_FRECUENCIA -- requirements
Module: divisor_frecuencia

Interface
REQ-001 Parameter DIVISOR, default 50000000, SHALL set the division ratio N: one salida period per N clock periods.
REQ-002 Parameter ANCHO, default $clog2(DIVISOR), SHALL set the internal counter width.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge, except REQ-017.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 habilitar  input  1  SHALL be the count enable; 1 = run, 0 = hold.
REQ-006 salida  output  1  SHALL be the divided clock, glitch-free and registered.
REQ-007 pulso  output  1  SHALL be a registered one-cycle strobe, asserted once per salida period.

Function
REQ-008 An internal counter c SHALL count 0..N-1 and wrap to 0, advancing by 1 on each rising edge where habilitar=1.
REQ-009 With H = floor(N/2), salida SHALL be 0 while c < N-H and 1 while c >= N-H.
- salida SHALL be produced by a flop driven from the next counter value, never decoded combinationally from c.
REQ-010 Even N SHALL give exactly 50% duty (N/2 cycles low, N/2 high).
REQ-011 Odd N SHALL give (N+1)/2 cycles low and (N-1)/2 cycles high, unless REQ-017 applies.
REQ-012 pulso SHALL be 1 for exactly the one clock cycle during which c = 0 following a wrap from N-1.
- pulso SHALL NOT assert in the first cycle after reset release.
REQ-013 With habilitar=0, c, salida and pulso SHALL hold their values.
- Exception: pulso SHALL drop to 0 after one held cycle, so it never stays high longer than one cycle.
REQ-014 N=2 SHALL produce salida toggling every rising edge (clock/2), with pulso asserted every second cycle.
REQ-015 DIVISOR < 2 SHALL cause an elaboration-time error; no runtime behaviour is defined for it.
REQ-016 All counter arithmetic SHALL be unsigned, ANCHO bits wide, and SHALL wrap only at N-1, never at 2^ANCHO.

Reset
REQ-018 While reset=1, c, salida and pulso SHALL be 0 immediately, independent of clock.
REQ-019 After reset deasserts, the first enabled rising edge SHALL move c from 0 to 1.
REQ-020 Reset asserted mid-period SHALL abort the period; the next period SHALL start full-length from c=0.

Configuration
REQ-017 Macro DIVISOR_FRECUENCIA_ODD50_EN selects the odd-N duty cycle.
- Defined, odd N: a falling-edge stage SHALL make salida rise half a clock period early, giving exactly N/2 clock periods high and N/2 low (50% duty).
- Defined, even N: no effect.
- Undefined: no falling-edge logic SHALL exist, and odd-N duty SHALL follow REQ-011.

Verification
REQ-021 N=4, habilitar=1, release reset, then 12 edges:
- salida per cycle = 0,0,1,1 repeating.
- pulso = 1 on cycles 4 and 8 after release.
REQ-022 N=5, macro undefined: salida = 0,0,0,1,1 repeating; pulso period = 5 cycles.
REQ-023 N=5, macro defined: salida high-time = 25 ns and low-time = 25 ns with a 10 ns clock.
REQ-024 N=4: drop habilitar for 3 cycles at c=2:
- salida holds 1 during the 3 held cycles.
- pulso stays 0.
- The sequence then resumes at c=3 without skipping.
REQ-025 N=4: assert reset asynchronously mid-cycle at c=3:
- salida and pulso go 0 within the same timestep, with no clock edge needed.
- After release, the full 0,0,1,1 pattern restarts.
REQ-026 N=2: salida period = 20 ns with a 10 ns clock; pulso high every other cycle.
